// File: rtl/demux_scan_pkg.sv
// rtl/demux_scan_pkg.sv - shared types and constants for the demux scan controller
package demux_scan_pkg;

  localparam int NUM_CH = 8;
  localparam int SEL_W  = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } scan_state_t;

  typedef logic [NUM_CH-1:0] word_t;
  typedef logic [SEL_W-1:0]  sel_t;

  localparam sel_t LAST_SLOT = sel_t'(NUM_CH - 1);

endpackage

// File: rtl/demux_scan_if.sv
// rtl/demux_scan_if.sv - word handshake and demux drive signals of the scan controller
interface demux_scan_if;
  import demux_scan_pkg::*;

  word_t i_Data;
  logic  i_Valid;
  logic  o_Ready;
  logic  i_Abort;
  logic  o_In;
  sel_t  o_Sel;
  logic  o_Busy;
  logic  o_Done;

  modport slave (
    input  i_Data, i_Valid, i_Abort,
    output o_Ready, o_In, o_Sel, o_Busy, o_Done
  );

  modport master (
    output i_Data, i_Valid, i_Abort,
    input  o_Ready, o_In, o_Sel, o_Busy, o_Done
  );

endinterface

// File: rtl/dwell_timer.sv
// rtl/dwell_timer.sv - per-slot dwell counter, wraps itself at terminal count
module dwell_timer #(
  parameter int DWELL = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tc
);

  localparam logic [7:0] LAST = 8'(DWELL - 1);

  logic [7:0] count;

  assign tc = en && (count == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= tc ? 8'd0 : count + 8'd1;
    end
  end

endmodule

// File: rtl/demux_scan_ctrl.sv
// rtl/demux_scan_ctrl.sv - serialises one word across an 8-way demux, DWELL cycles per channel
module demux_scan_ctrl
  import demux_scan_pkg::*;
#(
  parameter int DWELL = 4
) (
  input  logic         i_Clk,
  input  logic         i_Rst_L,
  demux_scan_if.slave  bus
);

  scan_state_t state, state_nx;
  sel_t        slot, slot_nx;
  word_t       word, word_nx;

  logic ready;
  logic accept;
  logic abort_scan;
  logic tc;

  logic in_q, in_nx;
  sel_t sel_q, sel_nx;
  logic busy_q, busy_nx;
  logic done_q, done_nx;

  assign ready      = (state == IDLE) && !bus.i_Abort;
  assign accept     = bus.i_Valid && ready;
  assign abort_scan = (state == SCAN) && bus.i_Abort;

  dwell_timer #(.DWELL(DWELL)) u_timer (
    .clk   (i_Clk),
    .rst_n (i_Rst_L),
    .en    (state == SCAN),
    .clr   (accept || abort_scan),
    .tc    (tc)
  );

  always_comb begin
    state_nx = state;
    slot_nx  = slot;
    word_nx  = word;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nx = SCAN;
          slot_nx  = '0;
          word_nx  = bus.i_Data;
        end
      end
      SCAN: begin
        if (bus.i_Abort) begin
          state_nx = IDLE;
          slot_nx  = '0;
        end else if (tc) begin
          if (slot == LAST_SLOT) begin
            state_nx = DONE;
            slot_nx  = '0;
          end else begin
            slot_nx = slot + sel_t'(1);
          end
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase

    // Outputs are decoded from the next state so they land registered in step with it.
    in_nx   = 1'b0;
    sel_nx  = '0;
    busy_nx = 1'b0;
    done_nx = (state_nx == DONE);
    if (state_nx == SCAN) begin
      busy_nx = 1'b1;
      sel_nx  = slot_nx;
      in_nx   = word_nx[slot_nx];
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state  <= IDLE;
      slot   <= '0;
      word   <= '0;
      in_q   <= 1'b0;
      sel_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= state_nx;
      slot   <= slot_nx;
      word   <= word_nx;
      in_q   <= in_nx;
      sel_q  <= sel_nx;
      busy_q <= busy_nx;
      done_q <= done_nx;
    end
  end

  assign bus.o_Ready = ready;
  assign bus.o_In    = in_q;
  assign bus.o_Sel   = sel_q;
  assign bus.o_Busy  = busy_q;
  assign bus.o_Done  = done_q;

endmodule

// File: tb/tb_demux_scan_ctrl.sv
// tb/tb_demux_scan_ctrl.sv - directed self-checking bench for demux_scan_ctrl
module tb_demux_scan_ctrl;
  import demux_scan_pkg::*;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  demux_scan_if if4();
  demux_scan_if if1();

  demux_scan_ctrl #(.DWELL(4)) u_dut4 (
    .i_Clk   (clk),
    .i_Rst_L (rst_n),
    .bus     (if4.slave)
  );

  demux_scan_ctrl #(.DWELL(1)) u_dut1 (
    .i_Clk   (clk),
    .i_Rst_L (rst_n),
    .bus     (if1.slave)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int pulses;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // {ready, busy, done, sel[2:0], in} expected k cycles after the acceptance edge
  function automatic logic [6:0] model(input logic [7:0] w, input int k, input int d);
    int s;
    if (k <= 8 * d) begin
      s = (k - 1) / d;
      return {1'b0, 1'b1, 1'b0, 3'(s), w[s]};
    end else if (k == 8 * d + 1) begin
      return 7'b0010000;
    end
    return 7'b1000000;
  endfunction

  function automatic logic [6:0] obs4();
    return {if4.o_Ready, if4.o_Busy, if4.o_Done, if4.o_Sel, if4.o_In};
  endfunction

  function automatic logic [6:0] obs1();
    return {if1.o_Ready, if1.o_Busy, if1.o_Done, if1.o_Sel, if1.o_In};
  endfunction

  initial begin
    rst_n = 1'b0;
    if4.i_Data = '0; if4.i_Valid = 1'b0; if4.i_Abort = 1'b0;
    if1.i_Data = '0; if1.i_Valid = 1'b0; if1.i_Abort = 1'b0;

    @(negedge clk);
    check_eq("rst4", obs4(), 7'b1000000);
    check_eq("rst1", obs1(), 7'b1000000);

    // accept on the first edge after reset release
    rst_n = 1'b1;
    if4.i_Data = 8'hA5; if4.i_Valid = 1'b1;
    for (int k = 1; k <= 34; k++) begin
      @(negedge clk);
      if4.i_Valid = 1'b0;
      check_eq($sformatf("a5_c%0d", k), obs4(), model(8'hA5, k, 4));
    end

    // valid together with abort in idle
    if4.i_Data = 8'h5A; if4.i_Valid = 1'b1; if4.i_Abort = 1'b1;
    #1 check_eq("va_ready", if4.o_Ready, 1'b0);
    @(negedge clk);
    check_eq("va_noacc", obs4(), 7'b0000000);
    if4.i_Abort = 1'b0; if4.i_Valid = 1'b0;
    #1 check_eq("va_idle", obs4(), 7'b1000000);

    // valid held, data churning during the scan
    @(negedge clk);
    if4.i_Data = 8'h3C; if4.i_Valid = 1'b1;
    for (int k = 1; k <= 34; k++) begin
      @(negedge clk);
      check_eq($sformatf("hold_c%0d", k), obs4(), model(8'h3C, k, 4));
      if (k == 33) if4.i_Data = 8'hC3;
      else if (k < 33) if4.i_Data = 8'(k * 29 + 1);
    end
    for (int j = 1; j <= 13; j++) begin
      @(negedge clk);
      if (j == 1) if4.i_Data = 8'h00;
      check_eq($sformatf("w2_c%0d", j), obs4(), model(8'hC3, j, 4));
    end

    // abort during slot 3
    if4.i_Abort = 1'b1; if4.i_Valid = 1'b0;
    @(negedge clk);
    check_eq("abort_out", obs4(), 7'b0000000);
    if4.i_Abort = 1'b0;
    #1 check_eq("abort_ready", if4.o_Ready, 1'b1);
    pulses = 0;
    repeat (40) begin
      @(negedge clk);
      if (if4.o_Done) pulses++;
    end
    check_eq("abort_nodone", pulses, 0);
    check_eq("abort_busy", if4.o_Busy, 1'b0);

    // DWELL=1: one slot per cycle
    if1.i_Data = 8'hFF; if1.i_Valid = 1'b1;
    pulses = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if1.i_Valid = 1'b0;
      if (if1.o_Done) pulses++;
      check_eq($sformatf("d1_c%0d", k), obs1(), model(8'hFF, k, 1));
    end
    check_eq("d1_pulses", pulses, 1);

    // asynchronous reset mid slot 5
    if4.i_Data = 8'hFF; if4.i_Valid = 1'b1;
    for (int k = 1; k <= 22; k++) begin
      @(negedge clk);
      if4.i_Valid = 1'b0;
      check_eq($sformatf("rs_c%0d", k), obs4(), model(8'hFF, k, 4));
    end
    #2 rst_n = 1'b0;
    #1 check_eq("rst_mid", obs4(), 7'b1000000);
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    repeat (40) begin
      @(negedge clk);
      if (if4.o_Done) pulses++;
    end
    check_eq("rst_nodone", pulses, 0);
    check_eq("rst_idle", obs4(), 7'b1000000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/demux_scan_ctrl.md
DEMUX_SCAN_CTRL -- requirements
Module: demux_scan_ctrl

Interface
REQ-001 The block SHALL have one clock, i_Clk; reset i_Rst_L SHALL be asynchronous and active-low.
REQ-002 Parameter DWELL, default 4: clock cycles each channel slot is held; legal range 1..255.
REQ-003 Port i_Clk  input  1  rising-edge clock.
REQ-004 Port i_Rst_L  input  1  asynchronous active-low reset.
REQ-005 Port i_Data  input  8  word to distribute; bit n targets channel n.
REQ-006 Port i_Valid  input  1  i_Data is valid.
REQ-007 Port o_Ready  output  1  block can accept a word this cycle.
REQ-008 Port i_Abort  input  1  terminate the current scan.
REQ-009 Port o_In  output  1  serial bit to the downstream 1-to-8 demux data input.
REQ-010 Port o_Sel  output  3  channel select to the downstream demux.
REQ-011 Port o_Busy  output  1  scan in progress.
REQ-012 Port o_Done  output  1  one-cycle pulse when a scan completes.

Function
REQ-013 States SHALL be IDLE, SCAN and DONE.
REQ-014 o_Ready SHALL equal (state==IDLE) && !i_Abort; it is combinational.
REQ-015 A word is accepted on a rising edge where i_Valid && o_Ready; i_Data is captured into a word register, slot=0, dwell=0, and the state goes IDLE->SCAN.
REQ-016 In SCAN: o_Sel=slot, o_In=word[slot], o_Busy=1, all registered outputs; the first slot is visible the cycle after acceptance.
REQ-017 The dwell counter SHALL count 0..DWELL-1 per slot. At DWELL-1: if slot<7, slot increments and dwell clears; if slot==7, the state goes SCAN->DONE.
REQ-018 SCAN SHALL last exactly 8*DWELL cycles, with each slot held exactly DWELL cycles. No wrap from slot 7 to slot 0 within one scan.
REQ-019 DONE SHALL last one cycle with o_Done=1, o_Busy=0, o_In=0 and o_Sel=0, then go to IDLE.
REQ-020 In IDLE: o_In=0, o_Sel=0, o_Busy=0, o_Done=0.
REQ-021 i_Data and i_Valid SHALL be ignored outside IDLE; the word register changes only on acceptance.
REQ-022 i_Abort high in SCAN SHALL force IDLE on the next edge, clear slot and dwell, and suppress o_Done.
REQ-023 i_Abort in DONE SHALL be ignored; o_Done still pulses.
REQ-024 i_Abort in IDLE SHALL block acceptance in that cycle and have no other effect.
REQ-025 Back-to-back words: the earliest next acceptance is the first IDLE cycle after DONE, giving a minimum word period of 8*DWELL+2 cycles.
REQ-026 For DWELL=1, o_Sel SHALL advance every cycle.

Reset
REQ-027 i_Rst_L low SHALL immediately force state=IDLE, slot=0, dwell=0, word=0, o_In=0, o_Sel=0, o_Busy=0 and o_Done=0, with o_Ready=1 while i_Abort=0.
REQ-028 Reset asserted mid-scan SHALL abandon the scan with no o_Done.
REQ-029 Leaving reset SHALL begin in IDLE, able to accept on the first edge after deassertion.

Structure
REQ-030 Shared package demux_scan_pkg SHALL hold the state enum (IDLE, SCAN, DONE), NUM_CH=8 and SEL_W=3.
REQ-031 One sub-module, dwell_timer (DWELL-parameterised counter with clear input and terminal-count output), SHALL implement the slot timing.
REQ-032 All outputs except o_Ready SHALL be registered.

Verification
REQ-033 DWELL=4, accept 8'hA5 -> o_Sel steps 0..7 with 4 cycles each; o_In sequence is 1,0,1,0,0,1,0,1; o_Done pulses 33 cycles after the acceptance edge; o_Ready returns high on the following cycle.
REQ-034 DWELL=1, accept 8'hFF -> o_In high for 8 consecutive cycles while o_Sel increments each cycle; one o_Done pulse.
REQ-035 DWELL=4, i_Abort pulsed during slot 3 -> next cycle o_Busy=0, o_In=0, o_Sel=0, o_Ready=1, no o_Done.
REQ-036 i_Valid held high with i_Data changing every cycle during a scan -> output bits follow the captured word only; the second word is accepted in the first IDLE cycle after DONE.
REQ-037 i_Valid and i_Abort high together in IDLE -> no acceptance, state remains IDLE.
REQ-038 i_Rst_L driven low asynchronously mid-slot 5 -> all outputs clear before the next clock edge; no o_Done after release.
